// File: rtl/kbyte_frame_alloc.sv
// kbyte_frame_alloc: sequential-scan allocator that maps 1 KB-aligned prefixes onto NSLOTS physical frames.
// Optional build macro KFRAME_BOOT_LOCK_EN reserves slot 0 for boot memory (prefix 0, permanently in use).
module kbyte_frame_alloc #(
    parameter int NSLOTS = 8,
    parameter int SLOT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [31:0]          req_prefix,
    output logic                 rsp_valid,
    output logic                 rsp_ok,
    output logic [SLOT_W-1:0]    rsp_slot,
    output logic [NSLOTS*32-1:0] prefix_bus,
    output logic [NSLOTS-1:0]    use_bus,
    output logic [SLOT_W:0]      free_count
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;

`ifdef KFRAME_BOOT_LOCK_EN
    localparam bit BOOT = 1'b1;
`else
    localparam bit BOOT = 1'b0;
`endif
    localparam logic [NSLOTS-1:0] USE_RST = NSLOTS'(BOOT);
    localparam logic [SLOT_W:0]   FC_RST  = (SLOT_W+1)'(NSLOTS - int'(BOOT));
    localparam logic [SLOT_W-1:0] LAST    = SLOT_W'(NSLOTS - 1);

    state_t                   state_q, state_d;
    logic [SLOT_W-1:0]        idx_q, idx_d;
    logic [SLOT_W-1:0]        free_slot_q, free_slot_d;
    logic [SLOT_W-1:0]        match_slot_q, match_slot_d;
    logic                     found_free_q, found_free_d;
    logic                     found_match_q, found_match_d;
    logic                     op_q, op_d;
    logic [31:0]              lat_q, lat_d;
    logic                     res_ok_q, res_ok_d;
    logic [SLOT_W-1:0]        res_slot_q, res_slot_d;
    logic [NSLOTS-1:0][31:0]  pfx_q, pfx_d;
    logic [NSLOTS-1:0]        use_q, use_d;
    logic [SLOT_W:0]          free_count_q, free_count_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_ok_q, rsp_ok_d;
    logic [SLOT_W-1:0]        rsp_slot_q, rsp_slot_d;

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_ok     = rsp_ok_q;
    assign rsp_slot   = rsp_slot_q;
    assign prefix_bus = pfx_q;
    assign use_bus    = use_q;
    assign free_count = free_count_q;

    // Next-state: accept in IDLE, scan one slot per cycle, apply the result, then emit a registered response.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        free_slot_d   = free_slot_q;
        match_slot_d  = match_slot_q;
        found_free_d  = found_free_q;
        found_match_d = found_match_q;
        op_d          = op_q;
        lat_d         = lat_q;
        res_ok_d      = res_ok_q;
        res_slot_d    = res_slot_q;
        pfx_d         = pfx_q;
        use_d         = use_q;
        rsp_valid_d   = 1'b0;
        rsp_ok_d      = 1'b0;
        rsp_slot_d    = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d       = SCAN;
                    idx_d         = '0;
                    found_free_d  = 1'b0;
                    found_match_d = 1'b0;
                    op_d          = req_op;
                    lat_d         = req_prefix & 32'hffff_fc00;
                end
            end
            SCAN: begin
                if (!use_q[idx_q] && !found_free_q && !(BOOT && idx_q == '0)) begin
                    found_free_d = 1'b1;
                    free_slot_d  = idx_q;
                end
                if (use_q[idx_q] && pfx_q[idx_q] == lat_q && !found_match_q) begin
                    found_match_d = 1'b1;
                    match_slot_d  = idx_q;
                end
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == LAST) ? COMMIT : SCAN;
            end
            COMMIT: begin
                res_ok_d   = 1'b0;
                res_slot_d = '0;
                if (!op_q) begin
                    if (!found_match_q && found_free_q) begin
                        use_d[free_slot_q] = 1'b1;
                        pfx_d[free_slot_q] = lat_q;
                        res_ok_d           = 1'b1;
                        res_slot_d         = free_slot_q;
                    end
                end else if (found_match_q && !(BOOT && match_slot_q == '0)) begin
                    use_d[match_slot_q] = 1'b0;
                    res_ok_d            = 1'b1;
                    res_slot_d          = match_slot_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_ok_d    = res_ok_q;
                rsp_slot_d  = res_slot_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        free_count_d = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            free_count_d = free_count_d + {{SLOT_W{1'b0}}, ~use_d[i]};
        end
        req_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            free_slot_q   <= '0;
            match_slot_q  <= '0;
            found_free_q  <= 1'b0;
            found_match_q <= 1'b0;
            op_q          <= 1'b0;
            lat_q         <= '0;
            res_ok_q      <= 1'b0;
            res_slot_q    <= '0;
            pfx_q         <= '0;
            use_q         <= USE_RST;
            free_count_q  <= FC_RST;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_ok_q      <= 1'b0;
            rsp_slot_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            free_slot_q   <= free_slot_d;
            match_slot_q  <= match_slot_d;
            found_free_q  <= found_free_d;
            found_match_q <= found_match_d;
            op_q          <= op_d;
            lat_q         <= lat_d;
            res_ok_q      <= res_ok_d;
            res_slot_q    <= res_slot_d;
            pfx_q         <= pfx_d;
            use_q         <= use_d;
            free_count_q  <= free_count_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ok_q      <= rsp_ok_d;
            rsp_slot_q    <= rsp_slot_d;
        end
    end

endmodule

// File: tb/tb_kbyte_frame_alloc.sv
// tb_kbyte_frame_alloc: directed and random requests checked against a table-level model of the allocator.
module tb_kbyte_frame_alloc;

    localparam int N = 8;
`ifdef KFRAME_BOOT_LOCK_EN
    localparam bit BOOT = 1'b1;
`else
    localparam bit BOOT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_op = 1'b0;
    logic [31:0]    req_prefix = '0;
    logic           req_ready, rsp_valid, rsp_ok;
    logic [2:0]     rsp_slot;
    logic [N*32-1:0] prefix_bus;
    logic [N-1:0]   use_bus;
    logic [3:0]     free_count;

    int checks = 0;
    int errors = 0;

    bit          m_use [N];
    logic [31:0] m_pfx [N];

    always #5 clk = ~clk;

    kbyte_frame_alloc #(.NSLOTS(N), .SLOT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_prefix(req_prefix), .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
        .rsp_slot(rsp_slot), .prefix_bus(prefix_bus), .use_bus(use_bus), .free_count(free_count)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_use[i] = 1'b0;
            m_pfx[i] = '0;
        end
        if (BOOT) m_use[0] = 1'b1;
    endtask

    task automatic model_op(input bit op, input logic [31:0] p, output bit ok, output logic [2:0] slot);
        int match;
        int free;
        logic [31:0] a;
        a = {p[31:10], 10'b0};
        match = -1;
        free = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_use[i] && m_pfx[i] == a) match = i;
            if (!m_use[i]) free = i;
        end
        ok = 1'b0;
        slot = '0;
        if (!op && match < 0 && free >= 0) begin
            m_use[free] = 1'b1;
            m_pfx[free] = a;
            ok = 1'b1;
            slot = 3'(free);
        end else if (op && match >= 0 && !(BOOT && match == 0)) begin
            m_use[match] = 1'b0;
            ok = 1'b1;
            slot = 3'(match);
        end
    endtask

    task automatic check_state(input string tag);
        logic [N-1:0]    eu;
        logic [N*32-1:0] ep;
        int              fc;
        fc = 0;
        for (int i = 0; i < N; i++) begin
            eu[i] = m_use[i];
            ep[32*i +: 32] = m_pfx[i];
            if (!m_use[i]) fc++;
        end
        check({tag, "_use"}, use_bus, eu);
        check({tag, "_fc"}, free_count, fc);
        check({tag, "_pfx"}, prefix_bus, ep);
    endtask

    task automatic do_op(input bit op, input logic [31:0] p, input int hold);
        bit         eok;
        logic [2:0] es;
        int         n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", n < 40, 1);
        req_valid = 1'b1;
        req_op = op;
        req_prefix = p;
        @(posedge clk);
        #1;
        if (hold == 0) req_valid = 1'b0;
        check("busy", req_ready, 0);
        model_op(op, p, eok, es);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            n++;
            #1;
            if (hold > 0 && n < 9) check("held_ready", req_ready, 0);
            if (hold > 0 && n >= hold) req_valid = 1'b0;
            if (rsp_valid) break;
        end
        check("latency", n, 10);
        check("rsp_ok", rsp_ok, eok);
        check("rsp_slot", rsp_slot, es);
        check_state("post");
        @(posedge clk);
        #1;
        check("pulse", rsp_valid, 0);
        check("ready_back", req_ready, 1);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) pulses++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_ok", rsp_ok, 0);
        check("rst_rsp_slot", rsp_slot, 0);
        check_state("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", req_ready, 1);
    endtask

    initial begin
        int pulses;
        model_reset();
        #2;
        do_reset();

        do_op(1'b0, 32'h0001_2345, 0);
`ifndef KFRAME_BOOT_LOCK_EN
        check("t1_slot", rsp_slot_seen(), 0);
        check("t1_use", use_bus, 8'h01);
        check("t1_fc", free_count, 7);
        check("t1_pfx0", prefix_bus[31:0], 32'h0001_2000);
`endif

        do_reset();
        do_op(1'b0, 32'h0000_2000, 0);
        do_op(1'b0, 32'h0000_2400, 0);
        do_op(1'b0, 32'h0000_2800, 0);
        do_op(1'b0, 32'h0000_2400, 0);
        for (int i = 0; i < 6; i++) do_op(1'b0, 32'h0000_2C00 + 32'(i) * 32'h400, 0);
        do_op(1'b0, 32'h0000_9000, 0);
        check("t3_full_fc", free_count, 0);
        do_op(1'b1, 32'h0000_2400, 0);
        do_op(1'b0, 32'h0000_9000, 0);

        do_op(1'b1, 32'h0000_7C00, 0);
        do_op(1'b1, 32'h0000_9000, 5);
        count_pulses(15, pulses);
        check("one_rsp", pulses, 0);

        @(negedge clk);
        req_valid = 1'b1;
        req_op = 1'b0;
        req_prefix = 32'h0000_5000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();
        count_pulses(20, pulses);
        check("abandon_rsp", pulses, 0);

        do_op(1'b1, 32'h0000_0000, 0);
        do_op(1'b0, 32'h0000_0400, 0);
        do_op(1'b0, 32'h0000_0000, 0);

        for (int k = 0; k < 40; k++) begin
            do_op($urandom_range(0, 2) == 0, 32'h0003_0000 | (32'($urandom_range(0, 11)) << 10) | 32'($urandom_range(0, 1023)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [2:0] rsp_slot_seen();
        for (int i = 0; i < N; i++) if (m_use[i] && m_pfx[i] == 32'h0001_2000) return 3'(i);
        return 3'd7;
    endfunction

endmodule

// File: doc/kbyte_frame_alloc.md
Name: kbyte_frame_alloc

Overview:
- Frame-mapping allocator that sits directly upstream of the per-frame 1 KB decoders.
- Owns NSLOTS physical 1 KB frames. For each frame it holds a 1 KB-aligned address prefix and a use bit, and drives these to the decoder instances as prefix_bus and use_bus.
- Software or the control unit requests allocation or release of a 1 KB region through a valid/ready handshake. The block scans the slots sequentially and returns a one-cycle response.

Parameters:
- NSLOTS, 8, number of physical 1 KB frames (≥2).
- SLOT_W, 3, width of a slot index; equals clog2(NSLOTS).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  1  0 = ALLOC, 1 = FREE.
- req_prefix  input  32  region address; bits [9:0] are ignored and stored as zero.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_ok  output  1  1 = operation succeeded; valid only while rsp_valid is high.
- rsp_slot  output  SLOT_W  slot allocated or freed; 0 on failure.
- prefix_bus  output  NSLOTS*32  slot i prefix at bits [32*i+31:32*i].
- use_bus  output  NSLOTS  slot i use bit.
- free_count  output  SLOT_W+1  number of slots with use bit 0.

Behaviour:
Reset:
- Asynchronous reset, active-low. While rst_n = 0:
  - state = IDLE, req_ready = 0.
  - rsp_valid = 0, rsp_ok = 0, rsp_slot = 0.
  - All prefixes = 0, use_bus = 0, free_count = NSLOTS.
- req_ready goes to 1 on the first clock after reset deasserts.

Handshake:
- A request is accepted on the edge where req_valid & req_ready are both 1.
- On acceptance, req_op and req_prefix & 32'hfffffc00 are latched.
- req_ready is 1 only in IDLE. No new request is accepted until the response has been issued.
- rsp_valid has no backpressure; the consumer must sample it in its single high cycle.

FSM:
- IDLE: on accept, go to SCAN, clear scan index to 0, clear the found-free and found-match flags.
- SCAN: examine one slot per cycle at the scan index.
  - Record the lowest-index slot with use = 0.
  - Record the lowest-index slot with use = 1 and prefix == latched prefix.
  - After examining slot NSLOTS-1, go to COMMIT.
  - Total duration is exactly NSLOTS cycles, independent of data.
- COMMIT: apply the result (see below), then go to RESP.
  - prefix_bus, use_bus and free_count change on this edge.
- RESP: rsp_valid = 1 for this cycle only, then go to IDLE.

Fixed latency: the acceptance edge is followed by NSLOTS+2 edges, after which rsp_valid is high. The next request can be accepted on the cycle after RESP.

Result rules:
- ALLOC, match found: rsp_ok = 0 (duplicate mapping). No state change.
- ALLOC, no match, free slot found: set use = 1 and prefix = latched prefix on the lowest free slot. rsp_ok = 1, rsp_slot = that slot. free_count decrements by 1.
- ALLOC, table full: rsp_ok = 0. No change.
- FREE, match found: clear use on the matching slot. Its prefix is retained. rsp_ok = 1, rsp_slot = that slot. free_count increments by 1.
- FREE, no match: rsp_ok = 0. No change.

Boundary conditions:
- free_count never underflows or overflows; it always equals the number of zero bits in use_bus.
- If rst_n asserts mid-SCAN or mid-COMMIT, the operation is abandoned. All state returns to reset values and no response is issued.
- If req_valid is asserted during SCAN, COMMIT or RESP, it is ignored and held upstream.

Optional Feature:
Macro: KFRAME_BOOT_LOCK_EN

Defined:
- Slot 0 is reserved for boot memory. Reset sets use[0] = 1, prefix[0] = 32'h00000000, free_count = NSLOTS-1.
- FREE targeting slot 0 returns rsp_ok = 0 and leaves slot 0 unchanged.
- ALLOC of prefix 0 returns a duplicate failure.
- The SCAN never selects slot 0 as a free slot.

Undefined:
- Slot 0 behaves like every other slot. All slots are free at reset.

Test Plan:
1. Reset, then ALLOC 32'h00012345 → after 10 edges: rsp_valid = 1, rsp_ok = 1, rsp_slot = 0; prefix[0] = 32'h00012000; use_bus = 8'h01; free_count = 7.
2. ALLOC 0x2000, 0x2400, 0x2800 back-to-back → slots 0, 1, 2. ALLOC 0x2400 again → rsp_ok = 0; use_bus stays 8'h07.
3. Fill all 8 slots, then ALLOC 0x9000 → rsp_ok = 0; free_count = 0. Then FREE 0x2400 (slot 1) → rsp_ok = 1, rsp_slot = 1. Then ALLOC 0x9000 → slot 1.
4. FREE an unmapped 0x7C00 → rsp_ok = 0; no bus change. Hold req_valid during SCAN → req_ready = 0; exactly one response per accepted request.
5. Assert rst_n low during SCAN cycle 3 of an ALLOC → use_bus = 0 and rsp_valid = 0 immediately; no response is issued after reset release.
6. With KFRAME_BOOT_LOCK_EN defined: after reset use_bus = 8'h01 and free_count = 7. FREE 0x0 → rsp_ok = 0. ALLOC 0x400 → slot 1.
